// File: rtl/run_pattern_if.sv
// Handshake bundle between the pattern source and its controller.
// start/operands flow in; w/busy/done flow out.
interface run_pattern_if #(
  parameter int LW = 8,
  parameter int CW = 4
);
  logic          start;
  logic [LW-1:0] run_len;
  logic [LW-1:0] gap_len;
  logic [CW-1:0] count;
  logic          w;
  logic          busy;
  logic          done;

  modport master (
    output start, run_len, gap_len, count,
    input  w, busy, done
  );

  modport slave (
    input  start, run_len, gap_len, count,
    output w, busy, done
  );
endinterface

// File: rtl/run_pattern_gen.sv
// Moore FSM emitting count runs of w=1 (run_len long, gap_len apart).
// Ports: clk, reset (async active-low), bus (start/operands in, w/busy/done out).
module run_pattern_gen #(
  parameter int LW = 8,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         reset,
  run_pattern_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] runs_q, runs_d;
  logic [LW-1:0] run_q, run_d;
  logic [LW-1:0] gap_q, gap_d;
  logic          w_q, w_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    runs_d  = runs_q;
    run_d   = run_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          run_d = bus.run_len;
          gap_d = bus.gap_len;
          if (bus.run_len == '0 ||
              bus.count == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            cyc_d   = bus.run_len - LW'(1);
            runs_d  = bus.count - CW'(1);
          end
        end
      end
      RUN: begin
        if (cyc_q != '0) begin
          cyc_d = cyc_q - LW'(1);
        end else if (runs_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = GAP;
          // zero gap still leaves one low cycle
          cyc_d = (gap_q == '0) ? '0
                : gap_q - LW'(1);
        end
      end
      GAP: begin
        if (cyc_q != '0) begin
          cyc_d = cyc_q - LW'(1);
        end else begin
          state_d = RUN;
          cyc_d   = run_q - LW'(1);
          runs_d  = runs_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // outputs registered straight from next state
  always_comb begin
    w_d    = (state_d == RUN);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      runs_q  <= '0;
      run_q   <= '0;
      gap_q   <= '0;
      w_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      runs_q  <= runs_d;
      run_q   <= run_d;
      gap_q   <= gap_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.w    = w_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_run_pattern_gen.sv
// Directed bench for run_pattern_gen.
// Hand-computed w/busy/done sequences per scenario.
module tb_run_pattern_gen;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  run_pattern_if #(.LW(8), .CW(4)) bus ();

  run_pattern_gen #(.LW(8), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_w"},    32'(bus.w),    0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask

  // wpat bit n-1 is the first cycle after accept
  task automatic go(input string tag,
                    input logic [7:0] rl,
                    input logic [7:0] gl,
                    input logic [3:0] cn,
                    input logic [31:0] wpat,
                    input int n,
                    input bit hold);
    bus.run_len = rl;
    bus.gap_len = gl;
    bus.count   = cn;
    bus.start   = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (!hold) bus.start = 1'b0;
      // latched copies must be used
      bus.run_len = 8'd1;
      bus.gap_len = 8'd0;
      bus.count   = 4'd15;
      chk($sformatf("%s_w%0d", tag, i),
          32'(bus.w), 32'(wpat[n-1-i]));
      chk($sformatf("%s_b%0d", tag, i),
          32'(bus.busy), 1);
      chk($sformatf("%s_d%0d", tag, i),
          32'(bus.done), 32'(i == n-1));
    end
  endtask

  initial begin
    int nb, nw, nd, g;
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.start   = 1'b0;
    bus.run_len = '0;
    bus.gap_len = '0;
    bus.count   = '0;
    #1;
    chk_idle("rst");
    #20;
    reset = 1'b1;
    step();
    chk_idle("idle0");

    // 1,0,0,1,0,0,1 then DONE
    go("t2", 8'd1, 8'd2, 4'd3,
       32'b10010010, 8, 1'b0);
    step();
    chk_idle("t2_end");

    // gap forced to 1
    go("t3", 8'd4, 8'd0, 4'd2,
       32'b1111011110, 10, 1'b0);
    step();
    chk_idle("t3_end");

    go("t4a", 8'd5, 8'd3, 4'd0,
       32'b0, 1, 1'b0);
    step();
    chk_idle("t4a_end");
    go("t4b", 8'd0, 8'd3, 4'd3,
       32'b0, 1, 1'b0);
    step();
    chk_idle("t4b_end");

    // start held: extra starts ignored,
    // re-accepted after DONE+IDLE
    go("t5a", 8'd2, 8'd1, 4'd2,
       32'b110110, 6, 1'b1);
    step();
    chk_idle("t5_gap");
    go("t5b", 8'd2, 8'd1, 4'd2,
       32'b110110, 6, 1'b0);
    step();
    chk_idle("t5_end");

    // reset in cycle 3 of a 5-long run
    bus.run_len = 8'd5;
    bus.gap_len = 8'd1;
    bus.count   = 4'd2;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("t6_pre_w", 32'(bus.w), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("t6_async");
    step();
    step();
    #2;
    reset = 1'b1;
    step();
    chk_idle("t6_norestart");
    go("t6", 8'd5, 8'd1, 4'd2,
       32'b111110111110, 12, 1'b0);
    step();
    chk_idle("t6_end");

    // max operands, zero gap
    bus.run_len = 8'd255;
    bus.gap_len = 8'd0;
    bus.count   = 4'd15;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    nb = 0;
    nw = 0;
    nd = 0;
    g  = 0;
    while (bus.busy && g < 5000) begin
      nb += 32'(bus.busy);
      nw += 32'(bus.w);
      nd += 32'(bus.done);
      g++;
      step();
    end
    chk("max_busy", nb, 3840);
    chk("max_w",    nw, 3825);
    chk("max_done", nd, 1);
    chk_idle("max_end");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
